// File: rtl/usb_pkg.sv
// Shared USB transceiver definitions: transmit FSM states, framing constants
// and the {dp,dm} line-state encodings also used by the receive side.
package usb_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SYNC    = 3'd1,
      S_DATA    = 3'd2,
      S_EOP_SE0 = 3'd3,
      S_EOP_J   = 3'd4
   } tx_state_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam logic [2:0] STUFF_LIMIT  = 3'd6;
   localparam logic [2:0] EOP_SE0_BITS = 3'd2;

   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10,
      LINE_SE1 = 2'b11
   } line_state_t;

endpackage

// File: rtl/tx_nrzi_stuff.sv
// NRZI encoder with bit-stuff tracking: counts consecutive 1s on the wire and
// flags when a stuffed 0 is due; dp/dm give the level the current bit produces.
module tx_nrzi_stuff
   import usb_pkg::*;
(
   input  logic clk,
   input  logic nRST,
   input  logic bit_tick,
   input  logic bit_en,
   input  logic raw_bit,
   input  logic stuff_clear,
   output logic stuff_req,
   output logic stuff_next,
   output logic dp,
   output logic dm
);

   logic [2:0] stuff_cnt_q, stuff_cnt_d;
   logic       level_q, level_d;
   logic       enc_level;

   assign enc_level = raw_bit ? level_q : ~level_q;

   always_comb begin
      level_d     = level_q;
      stuff_cnt_d = stuff_cnt_q;
      if (stuff_clear) begin
         level_d     = 1'b1;
         stuff_cnt_d = '0;
      end else if (bit_tick && bit_en) begin
         level_d = enc_level;
         if (!raw_bit)
            stuff_cnt_d = '0;
         else if (stuff_cnt_q != STUFF_LIMIT)
            stuff_cnt_d = stuff_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         level_q     <= 1'b1;
         stuff_cnt_q <= '0;
      end else begin
         level_q     <= level_d;
         stuff_cnt_q <= stuff_cnt_d;
      end
   end

   // stuff_next: the bit being sent now completes a run and forces a stuff after it
   assign stuff_req  = (stuff_cnt_q == STUFF_LIMIT);
   assign stuff_next = raw_bit && (stuff_cnt_q >= STUFF_LIMIT - 3'd1);
   assign dp         = enc_level;
   assign dm         = ~enc_level;

endmodule

// File: rtl/tx_fsm.sv
// Full-speed USB transmit sequencer: byte handshake with the link layer,
// SYNC / stuffed NRZI data / EOP framing, registered line drive.
module tx_fsm
   import usb_pkg::*;
(
   input  logic       clk,
   input  logic       nRST,
   input  logic       bit_tick,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_active,
   output logic       dp,
   output logic       dm,
   output logic       oe
);

   tx_state_t   state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        tx_ready_q, tx_ready_d;
   logic        tx_active_q, tx_active_d;
   logic        oe_q, oe_d;
   line_state_t line_q, line_d;

   logic enc_en, enc_bit, enc_clear;
   logic stuff_req, stuff_next, enc_dp, enc_dm;
   logic byte_end;

   tx_nrzi_stuff u_nrzi (
      .clk         (clk),
      .nRST        (nRST),
      .bit_tick    (bit_tick),
      .bit_en      (enc_en),
      .raw_bit     (enc_bit),
      .stuff_clear (enc_clear),
      .stuff_req   (stuff_req),
      .stuff_next  (stuff_next),
      .dp          (enc_dp),
      .dm          (enc_dm)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      tx_ready_d  = 1'b0;
      tx_active_d = tx_active_q;
      oe_d        = oe_q;
      line_d      = line_q;
      enc_en      = 1'b0;
      enc_bit     = 1'b0;
      enc_clear   = 1'b0;
      byte_end    = 1'b0;

      case (state_q)
         S_IDLE: begin
            enc_clear   = 1'b1;
            bit_cnt_d   = '0;
            line_d      = LINE_J;
            oe_d        = 1'b0;
            tx_active_d = 1'b0;
            if (tx_valid) begin
               shift_d    = tx_data;
               tx_ready_d = 1'b1;
               state_d    = S_SYNC;
            end
         end

         S_SYNC: begin
            enc_en  = 1'b1;
            enc_bit = SYNC_PATTERN[bit_cnt_q];
            if (bit_tick) begin
               line_d      = line_state_t'({enc_dp, enc_dm});
               oe_d        = 1'b1;
               tx_active_d = 1'b1;
               bit_cnt_d   = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_d = S_DATA;
            end
         end

         // A stuff tick with bit_cnt at 0 can only follow bit 7, so it ends the byte
         S_DATA: begin
            enc_en  = 1'b1;
            enc_bit = stuff_req ? 1'b0 : shift_q[0];
            if (bit_tick) begin
               line_d = line_state_t'({enc_dp, enc_dm});
               if (stuff_req) begin
                  byte_end = (bit_cnt_q == 3'd0);
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  byte_end  = (bit_cnt_q == 3'd7) && !stuff_next;
               end
               if (byte_end) begin
                  if (tx_valid) begin
                     shift_d    = tx_data;
                     tx_ready_d = 1'b1;
                  end else begin
                     bit_cnt_d = '0;
                     state_d   = S_EOP_SE0;
                  end
               end
            end
         end

         S_EOP_SE0: begin
            if (bit_tick) begin
               if (bit_cnt_q == EOP_SE0_BITS) begin
                  line_d  = LINE_J;
                  state_d = S_EOP_J;
               end else begin
                  line_d    = LINE_SE0;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         S_EOP_J: begin
            enc_clear = 1'b1;
            if (bit_tick) begin
               line_d      = LINE_J;
               oe_d        = 1'b0;
               tx_active_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            enc_clear   = 1'b1;
            bit_cnt_d   = '0;
            line_d      = LINE_J;
            oe_d        = 1'b0;
            tx_active_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         tx_ready_q  <= 1'b0;
         tx_active_q <= 1'b0;
         oe_q        <= 1'b0;
         line_q      <= LINE_J;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_ready_q  <= tx_ready_d;
         tx_active_q <= tx_active_d;
         oe_q        <= oe_d;
         line_q      <= line_d;
      end
   end

   assign tx_ready  = tx_ready_q;
   assign tx_active = tx_active_q;
   assign oe        = oe_q;
   assign dp        = line_q[1];
   assign dm        = line_q[0];

endmodule

// File: tb/tb_tx_fsm.sv
// Scoreboard bench for tx_fsm: hand-written wire symbol strings are queued per
// frame and a monitor pops one per bit time while the driver is enabled.
module tb_tx_fsm;

   logic       clk = 1'b0;
   logic       nRST;
   logic       bit_tick;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_active;
   logic       dp;
   logic       dm;
   logic       oe;

   tx_fsm dut (
      .clk       (clk),
      .nRST      (nRST),
      .bit_tick  (bit_tick),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_active (tx_active),
      .dp        (dp),
      .dm        (dm),
      .oe        (oe)
   );

   always #5 clk = ~clk;

   // Symbol = {dp, dm, oe, tx_active}
   localparam logic [3:0] SYM_K    = 4'b0111;
   localparam logic [3:0] SYM_J    = 4'b1011;
   localparam logic [3:0] SYM_SE0  = 4'b0011;
   localparam logic [3:0] SYM_IDLE = 4'b1000;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [3:0] exp_q[$];
   logic [7:0] tx_bytes[$];
   int         ready_ticks[$];
   int         tick_total   = 0;
   int         popped       = 0;
   int         tick_period  = 1;
   logic       prev_oe      = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushWire(input string wire_str);
      for (int i = 0; i < wire_str.len(); i++) begin
         case (wire_str[i])
            "K":     exp_q.push_back(SYM_K);
            "J":     exp_q.push_back(SYM_J);
            "0":     exp_q.push_back(SYM_SE0);
            default: exp_q.push_back(SYM_IDLE);
         endcase
      end
   endtask

   task automatic waitReady(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = tx_ready;
      end
      checkOutput({name, "_ready_wait"}, got, 1);
   endtask

   task automatic applyStimulus(input string name, input string wire_str);
      pushWire(wire_str);
      popped = 0;
      ready_ticks.delete();
      @(negedge clk);
      tx_data  = tx_bytes[0];
      tx_valid = 1'b1;
      for (int b = 0; b < tx_bytes.size(); b++) begin
         waitReady(name);
         if (b + 1 < tx_bytes.size())
            tx_data = tx_bytes[b + 1];
         else
            tx_valid = 1'b0;
      end
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
         @(negedge clk);
      repeat (4 * tick_period) @(negedge clk);
      checkOutput({name, "_drained"}, exp_q.size(), 0);
      checkOutput({name, "_ready_cnt"}, ready_ticks.size(), tx_bytes.size());
   endtask

   initial begin
      int div_cnt;
      div_cnt  = 0;
      bit_tick = 1'b0;
      forever begin
         @(negedge clk);
         bit_tick = (div_cnt == 0);
         div_cnt  = (div_cnt + 1 >= tick_period) ? 0 : div_cnt + 1;
      end
   end

   // Pops one expected symbol per bit time while oe is (or just was) high
   initial begin
      logic [3:0] s;
      forever begin
         @(posedge clk);
         if (bit_tick && nRST) begin
            #1;
            s = {dp, dm, oe, tx_active};
            if (s[1] || prev_oe) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL wire_extra: got %0h, expected no symbol", s);
               end else begin
                  checkOutput($sformatf("wire[%0d]", popped), s, exp_q.pop_front());
                  popped++;
               end
            end
            prev_oe = s[1];
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bit_tick) tick_total++;
         if (tx_ready) ready_ticks.push_back(tick_total);
      end
   end

   // Line outputs must not move on clocks without bit_tick
   initial begin
      logic [3:0] pre;
      forever begin
         @(negedge clk);
         pre = {dp, dm, oe, tx_active};
         @(posedge clk);
         if (!bit_tick && nRST) begin
            #1;
            if (nRST) checkOutput("hold_nontick", {dp, dm, oe, tx_active}, pre);
         end
      end
   end

   initial begin
      nRST     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset_dp", dp, 1);
      checkOutput("reset_dm", dm, 0);
      checkOutput("reset_oe", oe, 0);
      checkOutput("reset_active", tx_active, 0);
      checkOutput("reset_ready", tx_ready, 0);
      #2 nRST = 1'b1;

      tx_bytes = {8'hA5};
      applyStimulus("a5", "KJKJKJKKKJJKJJKK00JI");

      tx_bytes = {8'hFF};
      applyStimulus("ff", "KJKJKJKKKKKKKJJJJ00JI");

      tx_bytes = {8'hFC};
      applyStimulus("fc", "KJKJKJKKJKKKKKKKJ00JI");

      tx_bytes = {8'h01, 8'h02, 8'h03};
      applyStimulus("multi", "KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJK00JI");
      if (ready_ticks.size() >= 3) begin
         checkOutput("multi_gap1", ready_ticks[1] - ready_ticks[0], 16);
         checkOutput("multi_gap2", ready_ticks[2] - ready_ticks[1], 8);
      end

      tick_period = 4;
      tx_bytes = {8'h3C};
      applyStimulus("slow", "KJKJKJKKJKKKKKJK00JI");
      tick_period = 1;
      repeat (4) @(negedge clk);

      // Abort a frame during data bit 3
      pushWire("KJKJKJKKKJJKJJKK00JI");
      popped = 0;
      ready_ticks.delete();
      @(negedge clk);
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      waitReady("abort");
      tx_valid = 1'b0;
      for (int i = 0; i < 200 && popped < 12; i++)
         @(negedge clk);
      checkOutput("abort_reach_bit3", popped, 12);
      #2 nRST = 1'b0;
      #1;
      checkOutput("abort_dp", dp, 1);
      checkOutput("abort_dm", dm, 0);
      checkOutput("abort_oe", oe, 0);
      checkOutput("abort_active", tx_active, 0);
      exp_q.delete();
      prev_oe = 1'b0;
      repeat (2) @(negedge clk);
      #2 nRST = 1'b1;

      tx_bytes = {8'h00};
      applyStimulus("restart", "KJKJKJKKJKJKJKJK00JI");

      checkOutput("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
